// File: rtl/maxpool_2x2.sv
// Stride-2 2x2 max-pooling stage fed by the two-row line buffer.
// Keeps only even row pairs and emits one registered maximum per 2x2 window.
module maxpool_2x2 #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_in1,
  input  logic [DATA_W-1:0] d_in2,
  input  logic              in_valid,
  output logic [DATA_W-1:0] d_out,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int PAIR_W = (IMG_H > 2) ? $clog2(IMG_H - 1) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(IMG_H - 2);

  logic [COL_W-1:0]  col_q, col_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] dOut_q, dOut_d;
  logic              outValid_q, outValid_d;
  logic              frameDone_q, frameDone_d;
  logic [DATA_W-1:0] vMax;

  function automatic logic [DATA_W-1:0] maxOf(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic aWins;
    if (SIGNED != 0) aWins = ($signed(a) > $signed(b));
    else             aWins = (a > b);
    return aWins ? a : b;
  endfunction

  assign vMax = maxOf(d_in1, d_in2);

  // Even columns park the vertical max; odd columns of even pairs close the window.
  always_comb begin
    col_d       = col_q;
    pair_d      = pair_q;
    hold_d      = hold_q;
    dOut_d      = dOut_q;
    outValid_d  = 1'b0;
    frameDone_d = 1'b0;
    if (in_valid) begin
      if (!col_q[0]) begin
        hold_d = vMax;
      end else if (!pair_q[0]) begin
        dOut_d      = maxOf(hold_q, vMax);
        outValid_d  = 1'b1;
        frameDone_d = (pair_q == PAIR_LAST) && (col_q == COL_LAST);
      end
      if (col_q == COL_LAST) begin
        col_d  = '0;
        pair_d = (pair_q == PAIR_LAST) ? '0 : pair_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      pair_q      <= '0;
      hold_q      <= '0;
      dOut_q      <= '0;
      outValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      pair_q      <= pair_d;
      hold_q      <= hold_d;
      dOut_q      <= dOut_d;
      outValid_q  <= outValid_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign d_out      = dOut_q;
  assign out_valid  = outValid_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2: a signed and an unsigned 4x4 instance share
// one input stream and are checked against a per-window reference model.
module tb_maxpool_2x2;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic [31:0] v;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_in1 = '0;
  logic [31:0] d_in2 = '0;
  logic        in_valid = 1'b0;
  logic [31:0] dOutS, dOutU;
  logic        vS, vU, fdS, fdU;
  logic        prevValid = 1'b0;

  logic [31:0] img [0:H-1][0:W-1];
  exp_t        qS[$];
  exp_t        qU[$];
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  maxpool_2x2 #(.DATA_W(32), .IMG_W(W), .IMG_H(H), .SIGNED(1)) dutS (
    .clk(clk), .rst(rst), .d_in1(d_in1), .d_in2(d_in2), .in_valid(in_valid),
    .d_out(dOutS), .out_valid(vS), .frame_done(fdS));

  maxpool_2x2 #(.DATA_W(32), .IMG_W(W), .IMG_H(H), .SIGNED(0)) dutU (
    .clk(clk), .rst(rst), .d_in1(d_in1), .d_in2(d_in2), .in_valid(in_valid),
    .d_out(dOutU), .out_valid(vU), .frame_done(fdU));

  always @(posedge clk or posedge rst) begin
    if (rst) prevValid <= 1'b0;
    else     prevValid <= in_valid;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] refMax4(input logic [31:0] a, b, c, d, input bit sgn);
    logic [31:0] vals [4];
    logic [31:0] best;
    vals = '{a, b, c, d};
    best = a;
    for (int k = 1; k < 4; k++) begin
      if (sgn ? ($signed(vals[k]) > $signed(best)) : (vals[k] > best)) best = vals[k];
    end
    return best;
  endfunction

  // The pooled map is the max over each non-overlapping 2x2 block of the frame.
  task automatic pushExpected();
    exp_t e;
    for (int pr = 0; pr < H / 2; pr++) begin
      for (int pc = 0; pc < W / 2; pc++) begin
        e.done = (pr == H / 2 - 1) && (pc == W / 2 - 1);
        e.v = refMax4(img[2*pr][2*pc], img[2*pr][2*pc+1], img[2*pr+1][2*pc],
                      img[2*pr+1][2*pc+1], 1'b1);
        qS.push_back(e);
        e.v = refMax4(img[2*pr][2*pc], img[2*pr][2*pc+1], img[2*pr+1][2*pc],
                      img[2*pr+1][2*pc+1], 1'b0);
        qU.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      d_in1    = $urandom;
      d_in2    = $urandom;
    end
  endtask

  // gapMode: 0 continuous, 1 toggle every cycle, 2 random idle runs.
  task automatic applyStimulus(input int gapMode);
    pushExpected();
    for (int p = 0; p < H - 1; p++) begin
      for (int c = 0; c < W; c++) begin
        @(negedge clk);
        d_in1    = img[p][c];
        d_in2    = img[p+1][c];
        in_valid = 1'b1;
        if (gapMode == 1) idle(1);
        else if (gapMode == 2) idle($urandom_range(0, 3));
      end
    end
  endtask

  task automatic fillRandom();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = $urandom;
  endtask

  task automatic fillRamp(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 32'(base + r * W + c + 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (qS.size() != 0 || qU.size() != 0); i++) @(negedge clk);
    if (qS.size() != 0 || qU.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d/%0d windows still pending, expected 0", qS.size(), qU.size());
      qS.delete();
      qU.delete();
    end
  endtask

  task automatic checkResetState();
    checkOutput("rstDoutS", dOutS, 32'h0);
    checkOutput("rstDoutU", dOutU, 32'h0);
    checkOutput("rstValid", {30'b0, vS, vU}, 32'h0);
    checkOutput("rstDone", {30'b0, fdS, fdU}, 32'h0);
  endtask

  // Monitor: pops one expectation per out_valid pulse of each instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (vS) begin
        if (qS.size() == 0) begin
          checks++;
          $display("[TB] FAIL sUnexpected: got out_valid with d_out 0x%08h, expected none", dOutS);
        end else begin
          e = qS.pop_front();
          checkOutput("sDout", dOutS, e.v);
          checkOutput("sDone", {31'b0, fdS}, {31'b0, e.done});
          checkOutput("sLatency", {31'b0, prevValid}, 32'h1);
        end
      end else if (fdS) begin
        checks++;
        $display("[TB] FAIL sDoneAlone: got frame_done 1 with out_valid 0, expected 0");
      end
      if (vU) begin
        if (qU.size() == 0) begin
          checks++;
          $display("[TB] FAIL uUnexpected: got out_valid with d_out 0x%08h, expected none", dOutU);
        end else begin
          e = qU.pop_front();
          checkOutput("uDout", dOutU, e.v);
          checkOutput("uDone", {31'b0, fdU}, {31'b0, e.done});
        end
      end else if (fdU) begin
        checks++;
        $display("[TB] FAIL uDoneAlone: got frame_done 1 with out_valid 0, expected 0");
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkResetState();
    rst = 1'b0;

    fillRamp(0);
    applyStimulus(0);
    idle(2);
    drain();

    applyStimulus(1);
    idle(2);
    drain();

    // Window (0,0) distinguishes signed from unsigned compare.
    fillRandom();
    img[0][0] = 32'hFFFF_FFFD;
    img[0][1] = 32'h0000_0002;
    img[1][0] = 32'hFFFF_FFF9;
    img[1][1] = 32'hFFFF_FFFF;
    applyStimulus(0);
    idle(2);
    drain();

    // Reset mid-window with a pending half-window of 99.
    @(negedge clk);
    d_in1    = 32'd99;
    d_in2    = 32'd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 checkResetState();
    repeat (2) @(negedge clk);
    checkResetState();
    rst = 1'b0;
    fillRamp(-20);
    applyStimulus(0);
    idle(2);
    drain();

    fillRamp(0);
    applyStimulus(0);
    fillRandom();
    applyStimulus(0);
    idle(2);
    drain();

    for (int n = 0; n < 6; n++) begin
      fillRandom();
      applyStimulus(2);
    end
    idle(2);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
